// File: rtl/bus_mem_slave_pkg.sv
// Shared definitions for the bus memory responder: FSM state codes,
// bus-wide default widths and the data returned for an out-of-range read.
package bus_mem_slave_pkg;

  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_ADDR_W = 32;

  localparam logic [BUS_DATA_W-1:0] ERR_RDATA = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_DONE = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_DONE = 3'd4,
    ST_RELEASE = 3'd5
  } state_e;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_mem_slave_mem_array_sp.sv
// Single-port synchronous RAM with one-cycle registered read. Power-up
// contents are undefined; the host preloads words through bus writes.
module mem_array_sp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/bus_mem_slave.sv
// Word-addressed memory responder on the shared CPU bus with programmable
// read/write wait states, protocol/range error reporting and a release handshake.
module bus_mem_slave
  import bus_mem_slave_pkg::*;
#(
  parameter int unsigned DATA_W    = BUS_DATA_W,
  parameter int unsigned ADDR_W    = BUS_ADDR_W,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_q,
  input  logic              write_q,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              read_dn,
  output logic              write_dn,
  output logic              bus_busy,
  output logic              bus_err
);

  localparam int unsigned IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned MAX_LAT = max_lat(READ_LAT, WRITE_LAT);
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_inr;

  logic [ADDR_W-1:0]  w_off;
  logic               w_inr;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_ram_addr;
  logic               w_ram_we;
  logic [DATA_W-1:0]  w_rdata;

  assign w_off = addr_in - ADDR_W'(BASE_ADDR);
  assign w_inr = (addr_in >= ADDR_W'(BASE_ADDR)) && (w_off < ADDR_W'(MEM_DEPTH));
  assign w_idx = w_off[IDX_W-1:0];

  // In IDLE the RAM looks up the live address so a READ_LAT of 1 still has data ready.
  assign w_ram_addr = (r_state == ST_IDLE) ? w_idx : r_idx;
  assign w_ram_we   = (r_state == ST_WR_DONE) && r_inr;

  mem_array_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_inr    <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
      read_dn  <= 1'b0;
      write_dn <= 1'b0;
      bus_busy <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      data_out <= '0;
      data_oe  <= 1'b0;
      read_dn  <= 1'b0;
      write_dn <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (read_q && write_q) begin
            bus_err <= 1'b1;
            r_state <= ST_RELEASE;
          end else if (read_q) begin
            r_idx    <= w_idx;
            r_inr    <= w_inr;
            r_cnt    <= CNT_W'(READ_LAT - 1);
            bus_busy <= 1'b1;
            r_state  <= ST_RD_WAIT;
          end else if (write_q) begin
            r_idx    <= w_idx;
            r_inr    <= w_inr;
            r_wdata  <= data_in;
            r_cnt    <= CNT_W'(WRITE_LAT - 1);
            bus_busy <= 1'b1;
            r_state  <= ST_WR_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (r_cnt == '0) begin
            read_dn  <= 1'b1;
            data_oe  <= 1'b1;
            data_out <= r_inr ? w_rdata : DATA_W'(ERR_RDATA);
            bus_err  <= ~r_inr;
            r_state  <= ST_RD_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RD_DONE: begin
          bus_busy <= 1'b0;
          r_state  <= ST_RELEASE;
        end
        ST_WR_WAIT: begin
          if (r_cnt == '0) begin
            write_dn <= 1'b1;
            bus_err  <= ~r_inr;
            r_state  <= ST_WR_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_WR_DONE: begin
          bus_busy <= 1'b0;
          r_state  <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!read_q && !write_q) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
